// File: rtl/icdf_lut_arbiter.sv
// icdf_lut_arbiter: round-robin sharing of one fixed-latency ICDF_LUT among
// N_REQ requesters. One lookup per cycle is issued; a {vld,id} tag pipeline
// follows each lookup through the LUT so the returning word lands in the
// originating requester's one-entry result slot.

// Per-requester result slot: tracks the outstanding lookup and holds the result.
module icdf_res_slot #(
  parameter int ICDF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_grant,
  input  logic              i_cap,
  input  logic [ICDF_W-1:0] i_cap_data,
  input  logic              i_consume,
  output logic              o_pending,
  output logic              o_valid,
  output logic [ICDF_W-1:0] o_data
);
  logic              r_pending;
  logic              r_valid;
  logic [ICDF_W-1:0] r_data;

  // Lookup in flight from grant until the tag reaches the end of the pipe.
  // Grant and capture never coincide: a pending requester is not eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pending <= 1'b0;
    else if (i_grant) r_pending <= 1'b1;
    else if (i_cap)   r_pending <= 1'b0;
  end

  // Slot fill on capture, drain on handshake; data holds after consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_cap) begin
      r_valid <= 1'b1;
      r_data  <= i_cap_data;
    end else if (r_valid && i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
endmodule

module icdf_lut_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LUT_LAT = 2,
  parameter int CDF_W   = 32,
  parameter int ICDF_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*CDF_W-1:0]  req_cdf,
  output logic [N_REQ-1:0]        req_ready,
  output logic [CDF_W-1:0]        lut_cdf,
  input  logic [ICDF_W-1:0]       lut_icdf,
  output logic [N_REQ-1:0]        res_valid,
  output logic [N_REQ*ICDF_W-1:0] res_icdf,
  input  logic [N_REQ-1:0]        res_ready,
  output logic                    busy
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                     r_done;
  logic [IDW-1:0]           r_last;
  logic [CDF_W-1:0]         r_lut_cdf;
  logic [LUT_LAT:0]         r_vld_pipe;
  logic [LUT_LAT:0][IDW-1:0] r_id_pipe;

  logic [N_REQ-1:0] w_pend;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_gnt;
  logic [N_REQ-1:0] w_cap;
  logic [IDW-1:0]   w_ord [N_REQ];
  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_id;

  // Gates eligibility for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= 1'b1;
  end

  assign w_elig = req_valid & ~w_pend & ~res_valid & {N_REQ{r_done}};

  // Round-robin search order starting just after the last granted index.
  always_comb begin
    for (int k = 0; k < N_REQ; k++)
      w_ord[k] = IDW'((int'(r_last) + k + 1) % N_REQ);
  end

  // First eligible requester in search order wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_gnt_vld && w_elig[w_ord[k]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_ord[k];
      end
    end
    w_gnt = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;
  end

  assign req_ready = w_gnt;

  // Pointer advances only on a real grant; reset makes index 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_last <= IDW'(N_REQ - 1);
    else if (w_gnt_vld) r_last <= w_gnt_id;
  end

  // Registered LUT input; holds its value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_lut_cdf <= '0;
    else if (w_gnt_vld) r_lut_cdf <= req_cdf[w_gnt_id*CDF_W +: CDF_W];
  end

  assign lut_cdf = r_lut_cdf;

  // Tag pipe: stage k is visible k+1 cycles after the grant, so the last
  // stage lines up with the LUT output for that lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LUT_LAT-1:0], w_gnt_vld};
      r_id_pipe  <= {r_id_pipe[LUT_LAT-1:0], w_gnt_id};
    end
  end

  assign w_cap = r_vld_pipe[LUT_LAT] ? (N_REQ'(1) << r_id_pipe[LUT_LAT]) : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    icdf_res_slot #(.ICDF_W(ICDF_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_grant    (w_gnt[i]),
      .i_cap      (w_cap[i]),
      .i_cap_data (lut_icdf),
      .i_consume  (res_ready[i]),
      .o_pending  (w_pend[i]),
      .o_valid    (res_valid[i]),
      .o_data     (res_icdf[i*ICDF_W +: ICDF_W])
    );
  end

  assign busy = (|w_pend) | (|res_valid);
endmodule

// File: tb/tb_icdf_lut_arbiter.sv
// Bench for icdf_lut_arbiter: a transaction-level model (in-flight queue with
// due cycles, per-requester flags) is checked against the DUT every cycle,
// plus directed scenarios with literal expectations.
module tb_icdf_lut_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int CW  = 32;
  localparam int IW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*CW-1:0] req_cdf = '0;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   lut_cdf;
  logic [IW-1:0]   lut_icdf;
  logic [N-1:0]    res_valid;
  logic [N*IW-1:0] res_icdf;
  logic [N-1:0]    res_ready = '0;
  logic            busy;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  icdf_lut_arbiter #(.N_REQ(N), .LUT_LAT(LAT), .CDF_W(CW), .ICDF_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cdf(req_cdf),
    .req_ready(req_ready), .lut_cdf(lut_cdf), .lut_icdf(lut_icdf),
    .res_valid(res_valid), .res_icdf(res_icdf), .res_ready(res_ready),
    .busy(busy)
  );

  // Stand-in LUT: a fixed function with LAT cycles of delay, never reset.
  function automatic logic [IW-1:0] lut_f(input logic [CW-1:0] c);
    return c[31:16] ^ c[15:0];
  endfunction

  logic [CW-1:0] lp [LAT] = '{default: '0};
  always @(posedge clk) begin
    lp[0] <= lut_cdf;
    for (int k = 1; k < LAT; k++) lp[k] <= lp[k-1];
  end
  assign lut_icdf = lut_f(lp[LAT-1]);

  // ---------------- behavioural model ----------------
  typedef struct { int cap; int id; logic [IW-1:0] d; } flight_t;
  flight_t       q[$];
  bit            m_pend [N];
  bit            m_rv   [N];
  logic [IW-1:0] m_rd   [N];
  int            m_last;
  bit            m_done;
  logic [CW-1:0] m_lut;
  bit            m_gv;
  int            m_gid;
  int            cyc = 0;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_rv[i] = 0; m_rd[i] = '0; end
    m_last = N - 1; m_done = 0; m_lut = '0; q.delete();
  endtask

  task automatic m_arb();
    m_gv = 0; m_gid = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (!m_gv && rst_n && m_done && req_valid[idx] && !m_pend[idx] && !m_rv[idx]) begin
        m_gv = 1; m_gid = idx;
      end
    end
  endtask

  // Advance the model across one rising edge using the inputs held at it.
  task automatic m_edge();
    if (!rst_n) m_reset();
    else begin
      m_arb();
      for (int i = 0; i < N; i++) if (m_rv[i] && res_ready[i]) m_rv[i] = 0;
      if (q.size() > 0 && q[0].cap == cyc) begin
        m_rv[q[0].id] = 1; m_rd[q[0].id] = q[0].d; m_pend[q[0].id] = 0;
        void'(q.pop_front());
      end
      if (m_gv) begin
        flight_t f;
        m_lut = req_cdf[m_gid*CW +: CW];
        m_pend[m_gid] = 1;
        f.cap = cyc + 1 + LAT; f.id = m_gid; f.d = lut_f(m_lut);
        q.push_back(f);
        m_last = m_gid;
      end
      m_done = 1;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
  endtask

  task automatic compare();
    logic [N-1:0]    e_rdy, e_rv;
    logic [N*IW-1:0] e_ic;
    logic            e_busy;
    m_arb();
    e_rdy = m_gv ? (N'(1) << m_gid) : '0;
    e_busy = 0;
    for (int i = 0; i < N; i++) begin
      e_rv[i] = m_rv[i];
      e_ic[i*IW +: IW] = m_rd[i];
      e_busy |= m_rv[i] | m_pend[i];
    end
    chk("req_ready", 128'(req_ready), 128'(e_rdy));
    chk("lut_cdf",   128'(lut_cdf),   128'(m_lut));
    chk("res_valid", 128'(res_valid), 128'(e_rv));
    chk("res_icdf",  128'(res_icdf),  128'(e_ic));
    chk("busy",      128'(busy),      128'(e_busy));
  endtask

  // One cycle: model crosses the edge, new inputs go in 1 after, compare 1 later.
  task automatic step(input logic [N-1:0] rv, input logic [N*CW-1:0] cdf,
                      input logic [N-1:0] rr, input bit rst_rel);
    @(posedge clk);
    m_edge();
    #1;
    req_valid = rv; req_cdf = cdf; res_ready = rr;
    if (!rst_rel) begin rst_n = 1'b0; m_reset(); end
    else rst_n = 1'b1;
    #1;
    compare();
  endtask

  task automatic do_reset();
    step('0, '0, '1, 0);
    step('0, '0, '1, 0);
    step('0, '0, '1, 1);
  endtask

  logic [N*CW-1:0] v;
  logic [CW-1:0]   words [N] = '{32'h0001_0000, 32'h0000_0022, 32'h0300_0000, 32'hF0F0_0F0F};
  logic [IW-1:0]   icdfs [N] = '{16'h0001, 16'h0022, 16'h0300, 16'hFFFF};
  int              n_g1, n_g2, n_rv;

  initial begin
    m_reset();
    // Reset state and reset-done gating
    step('0, '0, '1, 0);
    chk("rst_lut_cdf", 128'(lut_cdf), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    step('0, '0, '1, 0);
    step(4'b1111, '1, '1, 1);
    chk("rdy_at_release", 128'(req_ready), 128'(0));
    step('0, '0, '1, 1);

    // Single request: grant cycle 0, result cycle 4
    v = '0; v[0 +: CW] = 32'h1234_5678;
    step(4'b0001, v, '1, 1);
    chk("single_rdy", 128'(req_ready), 128'(4'b0001));
    for (int c = 1; c <= 5; c++) begin
      step('0, v, '1, 1);
      if (c <= 4) chk("single_busy", 128'(busy), 128'(1));
      if (c == 4) begin
        chk("single_rv", 128'(res_valid), 128'(4'b0001));
        chk("single_icdf", 128'(res_icdf[0 +: IW]), 128'(16'h444C));
      end
      if (c == 5) chk("single_idle", 128'(busy), 128'(0));
    end

    // All four requesters at once
    do_reset();
    v = '0;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = words[i];
    for (int k = 0; k < 9; k++) begin
      step((k < N) ? N'(4'hF << k) : '0, v, '1, 1);
      if (k < N) chk("all4_rdy", 128'(req_ready), 128'(N'(1) << k));
      if (k >= 4 && k < 8) begin
        chk("all4_rv", 128'(res_valid), 128'(N'(1) << (k - 4)));
        chk("all4_icdf", 128'(res_icdf[(k-4)*IW +: IW]), 128'(icdfs[k-4]));
      end
    end

    // Round-robin fairness after a grant to 2
    do_reset();
    step(4'b0100, v, '1, 1);
    chk("rr_g2", 128'(req_ready), 128'(4'b0100));
    step(4'b1001, v, '1, 1);
    chk("rr_g3_first", 128'(req_ready), 128'(4'b1000));
    step(4'b0001, v, '1, 1);
    chk("rr_g0_next", 128'(req_ready), 128'(4'b0001));
    for (int k = 0; k < 8; k++) step('0, v, '1, 1);

    // Backpressure on slot 1
    n_g1 = 0; n_g2 = 0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) v[i*CW +: CW] = $urandom;
      step(4'b0110, v, 4'b1101, 1);
      if (req_ready[1]) n_g1++;
      if (req_ready[2]) n_g2++;
    end
    chk("bp_grants1", 128'(n_g1), 128'(1));
    chk("bp_grants2", 128'(n_g2), 128'(4));
    step(4'b0110, v, '1, 1);
    chk("bp_pulse_rdy1", 128'(req_ready[1]), 128'(0));
    step(4'b0010, v, 4'b1101, 1);
    chk("bp_after_rdy", 128'(req_ready), 128'(4'b0010));
    for (int k = 0; k < 8; k++) step('0, v, '1, 1);

    // Reset mid-flight
    do_reset();
    step(4'b0001, v, '1, 1);
    step(4'b0010, v, '1, 1);
    step('0, v, '1, 0);
    chk("mid_lut_cdf", 128'(lut_cdf), 128'(0));
    chk("mid_rv", 128'(res_valid), 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_rdy", 128'(req_ready), 128'(0));
    step('0, v, '1, 1);
    n_rv = 0;
    for (int k = 0; k < 10; k++) begin
      step('0, v, '1, 1);
      if (res_valid != '0) n_rv++;
    end
    chk("mid_no_result", 128'(n_rv), 128'(0));

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] rv, rr;
      for (int i = 0; i < N; i++) begin
        v[i*CW +: CW] = $urandom;
        rv[i] = ($urandom_range(0, 2) != 0);
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      step(rv, v, rr, $urandom_range(0, 399) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icdf_lut_arbiter.md
# icdf_lut_arbiter

Round-robin arbiter that shares one ICDF_LUT instance among N_REQ Sobol dimension generators. Each requester submits a 32-bit CDF word with a valid/ready handshake. The arbiter issues at most one lookup per cycle to the LUT and tracks in-flight lookups through the LUT's fixed latency with an ID tag pipeline. It then returns each 16-bit ICDF result to the originating requester through a one-entry result slot with valid/ready handshake. The block sits between the Sobol generators and the ICDF_LUT in the sampling datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LUT_LAT, 2, ICDF_LUT latency: cdf presented in cycle t yields icdf valid in cycle t+LUT_LAT
- CDF_W, 32, CDF word width
- ICDF_W, 16, ICDF word width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i has a CDF word pending
- req_cdf  in  N_REQ*CDF_W  requester i word at bits [i*CDF_W +: CDF_W]
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- lut_cdf  out  CDF_W  registered CDF to ICDF_LUT.cdf
- lut_icdf  in  ICDF_W  from ICDF_LUT.icdf
- res_valid  out  N_REQ  result slot i full
- res_icdf  out  N_REQ*ICDF_W  slot i data at bits [i*ICDF_W +: ICDF_W]
- res_ready  in  N_REQ  requester i consumes slot i when res_valid[i] && res_ready[i]
- busy  out  1  any lookup in flight or any result slot full

## Operation
- Per requester i, two state flags:
  - pending[i]: lookup issued, result not yet captured
  - res_valid[i]: result captured, not yet consumed
- Eligibility: elig[i] = req_valid[i] && !pending[i] && !res_valid[i]. At most one outstanding transaction per requester.
- Grant: pick the first eligible index in round-robin order starting at last_grant+1 (mod N_REQ). last_grant updates only on an actual grant; reset value N_REQ-1, so index 0 has first priority.
- req_ready is combinational from elig and the round-robin pointer. It may depend on req_valid. At most one bit is high per cycle.
- On grant of i in cycle t:
  - lut_cdf <= req_cdf[i] (visible from cycle t+1)
  - pending[i] <= 1
  - tag pipeline stage 0 <= {1, i}
- No grant: lut_cdf holds its value; stage 0 <= {0, x} (bubble).
- Tag pipeline: LUT_LAT+1 stages of {vld, id[$clog2(N_REQ)-1:0]}, shifting every cycle.
- A tag with vld=1 at the last stage marks lut_icdf as valid for that id in that cycle. At that edge:
  - res_icdf[id] <= lut_icdf
  - res_valid[id] <= 1
  - pending[id] <= 0
- Result consume: res_valid[i] <= 0 on the res_valid[i] && res_ready[i] edge; res_icdf[i] holds its value.
- Capture and consume cannot collide on the same slot: pending and res_valid are mutually exclusive by construction.
- A requester freed by consumption in cycle t is eligible again in cycle t+1, not t.
- No arithmetic on data paths; words pass through unmodified.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - lut_cdf=0, res_icdf=0, res_valid=0, pending=0, busy=0
  - tag pipeline all vld=0, last_grant=N_REQ-1
  - req_ready is 0 until the cycle after rst_n rises, since elig is gated by a registered reset-done flag.
- Latency: grant in cycle t → lut_cdf in t+1 → lut_icdf valid in t+1+LUT_LAT → res_valid high from cycle t+2+LUT_LAT (t+4 by default).
- Throughput:
  - One grant per cycle overall.
  - A single requester with res_ready tied high issues once per LUT_LAT+3 cycles (5 by default).
- Reset mid-operation: all in-flight tags and full slots are discarded and no result is delivered. LUT outputs arriving after reset are ignored because the tags are invalid.
- Results are returned in issue order across requesters.
- busy = |pending | |res_valid.

## Test plan
- Single request: reset, then req_valid[0]=1, req_cdf[0]=first entry of cdf.dat in cycle 0, against a real ICDF_LUT → req_ready[0]=1 in cycle 0; res_valid[0] rises in cycle 4 with res_icdf[0]=first entry of icdf.dat; busy=1 from cycle 1 to cycle 4.
- All four requesters valid in cycle 0 with distinct cdf.dat words → grants to 0,1,2,3 in cycles 0..3; res_valid[0..3] rise in cycles 4..7 with matching icdf.dat values.
- Round-robin fairness: after the last grant goes to 2, requesters 0 and 3 become valid together → 3 is granted first, then 0 the next cycle.
- Backpressure: res_ready[1]=0 for 20 cycles with req_valid[1..2]=1 continuously → req_ready[1] stays 0 while slot 1 is full; requester 2 keeps being granted every 5 cycles; after res_ready[1] pulses, req_ready[1] can rise no earlier than the following cycle.
- Reset mid-flight: assert rst_n=0 in cycle 2 after grants in cycles 0 and 1 → all outputs read their reset values immediately; no res_valid in the following 10 cycles.
- LUT_LAT=3 build with a delayed LUT model → results arrive in cycle t+5; a 100-pattern cdf.dat/icdf.dat sweep shows zero mismatches.
